// File: rtl/sf_request_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sf_request_sequencer_if                                      |
// | Description : Job, generator and output bundle of sf_request_sequencer.    |
// |               SF_SEQ_PERF_EN adds the perf_stall/perf_pixels counters.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface sf_request_sequencer_if #(
  parameter int FIXEDBITS = 32,
  parameter int COORDW    = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [COORDW-1:0]    cfg_width;
  logic [COORDW-1:0]    cfg_height;
  logic [FIXEDBITS-1:0] cfg_fx;
  logic [FIXEDBITS-1:0] cfg_fy;

  logic                 sfg_ready;
  logic                 sfg_done;
  logic [FIXEDBITS-1:0] sfg_fx;
  logic [FIXEDBITS-1:0] sfg_fy;
  logic [FIXEDBITS-1:0] sfg_sx;
  logic [FIXEDBITS-1:0] sfg_sy;
  logic                 sfg_start;
  logic                 sfg_taken;
  logic [FIXEDBITS-1:0] sfg_factorX;
  logic [FIXEDBITS-1:0] sfg_factorY;
  logic [COORDW-1:0]    sfg_dx;
  logic [COORDW-1:0]    sfg_dy;

  logic                 out_valid;
  logic                 out_ready;
  logic [COORDW-1:0]    out_dx;
  logic [COORDW-1:0]    out_dy;
  logic [FIXEDBITS-1:0] out_sx;
  logic [FIXEDBITS-1:0] out_sy;
  logic [FIXEDBITS-1:0] out_fx;
  logic [FIXEDBITS-1:0] out_fy;
  logic                 out_last;
  logic                 job_done;
`ifdef SF_SEQ_PERF_EN
  logic [31:0]          perf_stall;
  logic [31:0]          perf_pixels;
`endif

  modport master (
    input  cfg_valid, cfg_width, cfg_height, cfg_fx, cfg_fy,
    input  sfg_ready, sfg_done, sfg_fx, sfg_fy, sfg_sx, sfg_sy, out_ready,
    output cfg_ready, sfg_start, sfg_taken, sfg_factorX, sfg_factorY, sfg_dx, sfg_dy,
    output out_valid, out_dx, out_dy, out_sx, out_sy, out_fx, out_fy, out_last, job_done
`ifdef SF_SEQ_PERF_EN
    , output perf_stall, perf_pixels
`endif
  );

  modport slave (
    output cfg_valid, cfg_width, cfg_height, cfg_fx, cfg_fy,
    output sfg_ready, sfg_done, sfg_fx, sfg_fy, sfg_sx, sfg_sy, out_ready,
    input  cfg_ready, sfg_start, sfg_taken, sfg_factorX, sfg_factorY, sfg_dx, sfg_dy,
    input  out_valid, out_dx, out_dy, out_sx, out_sy, out_fx, out_fy, out_last, job_done
`ifdef SF_SEQ_PERF_EN
    , input perf_stall, perf_pixels
`endif
  );
endinterface
`default_nettype wire

// File: rtl/sf_request_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sf_request_sequencer                                         |
// | Description : Raster-order requester for the scale-factor generator with a |
// |               2-entry result FIFO. SF_SEQ_PERF_EN adds stall/pixel counts. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sf_request_sequencer #(
  parameter int FIXEDBITS = 32,
  parameter int FRAC      = 18,
  parameter int COORDW    = 16
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  sf_request_sequencer_if.master bus
);

  generate
    if (FRAC >= FIXEDBITS) begin : g_frac_range_err
      $error("FRAC must be smaller than FIXEDBITS");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  typedef struct packed {
    logic [COORDW-1:0]    dx;
    logic [COORDW-1:0]    dy;
    logic [FIXEDBITS-1:0] sx;
    logic [FIXEDBITS-1:0] sy;
    logic [FIXEDBITS-1:0] fx;
    logic [FIXEDBITS-1:0] fy;
    logic                 last;
  } entry_t;

  state_t               r_state;
  logic                 r_cfg_ready;
  logic                 r_taken;
  logic                 r_job_done;
  logic [COORDW-1:0]    r_width;
  logic [COORDW-1:0]    r_height;
  logic [COORDW-1:0]    r_dx;
  logic [COORDW-1:0]    r_dy;
  logic [FIXEDBITS-1:0] r_fx;
  logic [FIXEDBITS-1:0] r_fy;

  entry_t               r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  logic   w_accept;
  logic   w_full;
  logic   w_push;
  logic   w_pop;
  logic   w_last;
  entry_t w_entry;
  entry_t w_head;

  assign w_accept = (r_state == S_IDLE) && bus.cfg_valid;
  assign w_full   = (r_count == 2'd2);
  assign w_push   = (r_state == S_CAPTURE);
  assign w_pop    = bus.out_valid && bus.out_ready;
  assign w_last   = (r_dx == r_width - COORDW'(1)) && (r_dy == r_height - COORDW'(1));

  assign w_entry = '{dx: r_dx, dy: r_dy, sx: bus.sfg_sx, sy: bus.sfg_sy,
                     fx: bus.sfg_fx, fy: bus.sfg_fy, last: w_last};
  assign w_head  = r_mem[r_rd_ptr];

  // Request/response sequencing; CAPTURE is the only state that pushes the FIFO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cfg_ready <= 1'b1;
      r_taken     <= 1'b0;
      r_job_done  <= 1'b0;
      r_width     <= '0;
      r_height    <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_fx        <= '0;
      r_fy        <= '0;
    end else begin
      r_job_done <= 1'b0;
      r_taken    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            r_width  <= bus.cfg_width;
            r_height <= bus.cfg_height;
            r_fx     <= bus.cfg_fx;
            r_fy     <= bus.cfg_fy;
            r_dx     <= '0;
            r_dy     <= '0;
            if ((bus.cfg_width == '0) || (bus.cfg_height == '0)) begin
              r_job_done <= 1'b1;
            end else begin
              r_state     <= S_ISSUE;
              r_cfg_ready <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (bus.sfg_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Holding off taken while full keeps the generator's result parked.
          if (bus.sfg_done && !w_full) begin
            r_state <= S_CAPTURE;
            r_taken <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (w_last) begin
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_ISSUE;
            if (r_dx == r_width - COORDW'(1)) begin
              r_dx <= '0;
              r_dy <= r_dy + COORDW'(1);
            end else begin
              r_dx <= r_dx + COORDW'(1);
            end
          end
        end
        S_DRAIN: begin
          if ((r_count == 2'd0) || (w_pop && (r_count == 2'd1))) begin
            r_job_done  <= 1'b1;
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.cfg_ready   = r_cfg_ready;
  assign bus.sfg_start   = (r_state == S_ISSUE) && bus.sfg_ready;
  assign bus.sfg_taken   = r_taken;
  assign bus.sfg_factorX = r_fx;
  assign bus.sfg_factorY = r_fy;
  assign bus.sfg_dx      = r_dx;
  assign bus.sfg_dy      = r_dy;
  assign bus.out_valid   = (r_count != 2'd0);
  assign bus.out_dx      = w_head.dx;
  assign bus.out_dy      = w_head.dy;
  assign bus.out_sx      = w_head.sx;
  assign bus.out_sy      = w_head.sy;
  assign bus.out_fx      = w_head.fx;
  assign bus.out_fy      = w_head.fy;
  assign bus.out_last    = w_head.last;
  assign bus.job_done    = r_job_done;

`ifdef SF_SEQ_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_pixels;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_stall  <= '0;
      r_perf_pixels <= '0;
    end else if (w_accept) begin
      r_perf_stall  <= '0;
      r_perf_pixels <= '0;
    end else begin
      if ((r_state == S_WAIT) && bus.sfg_done && w_full && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
      if ((r_state == S_CAPTURE) && (r_perf_pixels != '1))
        r_perf_pixels <= r_perf_pixels + 32'd1;
    end
  end

  assign bus.perf_stall  = r_perf_stall;
  assign bus.perf_pixels = r_perf_pixels;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sf_request_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sf_request_sequencer                                      |
// | Description : Bench for sf_request_sequencer with a generator model and a  |
// |               raster-order scoreboard (SF_SEQ_PERF_EN adds counter tests). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sf_request_sequencer;
  localparam int FB = 32;
  localparam int FR = 18;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sf_request_sequencer_if #(.FIXEDBITS(FB), .COORDW(CW)) bus ();
  sf_request_sequencer #(.FIXEDBITS(FB), .FRAC(FR), .COORDW(CW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct packed {
    logic [15:0] dx, dy;
    logic [31:0] sx, sy, fx, fy;
    logic        last;
  } ent_t;

  ent_t exp_q[$];
  ent_t got_q[$];
  int total = 0, bad = 0;
  int done_cnt = 0, start_cnt = 0, taken_cnt = 0, viol = 0, occ = 0;

  // Centre-aligned source position: (d+0.5)*f - 0.5, clamped at 0; {integer, fraction}.
  function automatic logic [63:0] map_coord(input logic [15:0] d, input logic [31:0] f);
    longint p;
    p = ((2 * longint'(d) + 1) * longint'(f) - (longint'(1) << FR)) / 2;
    if (p < 0) p = 0;
    return {32'(p >>> FR), 32'(p & ((longint'(1) << FR) - 1))};
  endfunction

  // Generator model: idle -> busy on start, result 5 cycles later, held until taken.
  logic        g_busy, g_done, gen_block;
  int          g_cnt;
  logic [31:0] g_sx, g_sy, g_fx, g_fy;
  logic [95:0] g_req;
  assign bus.sfg_ready = !g_busy && !gen_block;
  assign bus.sfg_done  = g_done;
  assign bus.sfg_sx    = g_sx;
  assign bus.sfg_sy    = g_sy;
  assign bus.sfg_fx    = g_fx;
  assign bus.sfg_fy    = g_fy;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      g_busy <= 1'b0; g_done <= 1'b0; g_cnt <= 0; g_req <= '0;
      g_sx <= '0; g_sy <= '0; g_fx <= '0; g_fy <= '0;
    end else if (bus.sfg_start && bus.sfg_ready) begin
      g_busy <= 1'b1;
      g_cnt  <= 4;
      g_req  <= {bus.sfg_dx, bus.sfg_dy, bus.sfg_factorX, bus.sfg_factorY};
      {g_sx, g_fx} <= map_coord(bus.sfg_dx, bus.sfg_factorX);
      {g_sy, g_fy} <= map_coord(bus.sfg_dy, bus.sfg_factorY);
    end else if (g_busy && !g_done) begin
      if (g_cnt == 0) g_done <= 1'b1;
      else g_cnt <= g_cnt - 1;
    end else if (g_done && bus.sfg_taken) begin
      g_done <= 1'b0;
      g_busy <= 1'b0;
    end
  end

  // Protocol monitor sampled mid-cycle; occ is the bench's own FIFO occupancy.
  ent_t head, hold_e;
  logic hold;
  assign head = '{dx: bus.out_dx, dy: bus.out_dy, sx: bus.out_sx, sy: bus.out_sy,
                  fx: bus.out_fx, fy: bus.out_fy, last: bus.out_last};

  always @(negedge clk) begin
    if (!resetn) begin
      occ = 0;
      hold = 1'b0;
    end else begin
      if (bus.out_valid !== (occ != 0)) viol++;
      if (hold && (!bus.out_valid || head !== hold_e)) viol++;
      hold   = bus.out_valid && !bus.out_ready;
      hold_e = head;
      if (bus.sfg_start) begin start_cnt++; if (!bus.sfg_ready) viol++; end
      if (bus.sfg_taken) begin taken_cnt++; if (!bus.sfg_done || occ >= 2) viol++; end
      if (g_busy && g_req !== {bus.sfg_dx, bus.sfg_dy, bus.sfg_factorX, bus.sfg_factorY}) viol++;
      if (bus.job_done) done_cnt++;
      if (bus.out_valid && bus.out_ready) got_q.push_back(head);
      occ = occ + (bus.sfg_taken ? 1 : 0) - ((bus.out_valid && bus.out_ready) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_expected(input int w, input int h, input logic [31:0] fx, input logic [31:0] fy);
    logic [63:0] mx, my;
    exp_q.delete();
    got_q.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        mx = map_coord(16'(x), fx);
        my = map_coord(16'(y), fy);
        exp_q.push_back('{dx: 16'(x), dy: 16'(y), sx: mx[63:32], sy: my[63:32],
                          fx: mx[31:0], fy: my[31:0], last: (x == w - 1) && (y == h - 1)});
      end
  endtask

  task automatic accept_job(input int w, input int h, input logic [31:0] fx, input logic [31:0] fy);
    bus.cfg_width  = 16'(w);
    bus.cfg_height = 16'(h);
    bus.cfg_fx     = fx;
    bus.cfg_fy     = fy;
    bus.cfg_valid  = 1'b1;
    step();
    bus.cfg_valid  = 1'b0;
  endtask

  task automatic wait_job_done(input int budget, input bit rand_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      if (bus.job_done) begin ok = 1'b1; break; end
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    bus.cfg_valid = 0; bus.cfg_width = 0; bus.cfg_height = 0; bus.cfg_fx = 0; bus.cfg_fy = 0;
    bus.out_ready = 1; gen_block = 0;
    resetn = 1'b0;
    repeat (3) step();
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", bus.cfg_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.sfg_start !== 1'b0 || bus.sfg_taken !== 1'b0 || bus.job_done !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got start=%b taken=%b done=%b exp=0", bus.sfg_start, bus.sfg_taken, bus.job_done); end
    total++; if (bus.sfg_dx !== 16'd0 || bus.sfg_dy !== 16'd0 || bus.sfg_factorX !== 32'd0) begin
      bad++; $display("FAIL reset_coord got dx=%0d dy=%0d fX=%0h exp=0", bus.sfg_dx, bus.sfg_dy, bus.sfg_factorX); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok; int d0, v0;
    build_expected(2, 2, 32'h40000, 32'h40000);
    d0 = done_cnt; v0 = viol; bus.out_ready = 1'b1;
    accept_job(2, 2, 32'h40000, 32'h40000);
    total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL basic_busy cfg_ready=%b exp=0", bus.cfg_ready); end
    wait_job_done(200, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout job_done=0 exp=1"); end
    step();
    total++; if (bus.job_done !== 1'b0) begin bad++; $display("FAIL basic_pulse job_done=%b exp=0", bus.job_done); end
    step();
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_q[i].sx !== 32'(got_q[i].dx) || got_q[i].sy !== 32'(got_q[i].dy) ||
          got_q[i].fx !== 0 || got_q[i].fy !== 0 || got_q[i].last !== (i == 3)) begin
        bad++; $display("FAIL basic_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
    total++; if (viol != v0) begin bad++; $display("FAIL basic_protocol violations=%0d exp=0", viol - v0); end
  endtask

  task automatic test_half_scale();
    bit ok;
    build_expected(2, 1, 32'h20000, 32'h40000);
    accept_job(2, 1, 32'h20000, 32'h40000);
    wait_job_done(200, 1'b0, ok);
    step();
    total++; if (!ok || got_q.size() != 2) begin bad++; $display("FAIL half_count got=%0d exp=2 ok=%0d", got_q.size(), ok); end
    else begin
      total++; if (got_q[1].dx !== 16'd1 || got_q[1].sx !== 32'd0 || got_q[1].fx !== 32'd65536) begin
        bad++; $display("FAIL half_dx1 got dx=%0d sx=%0d fx=%0d exp dx=1 sx=0 fx=65536", got_q[1].dx, got_q[1].sx, got_q[1].fx); end
      total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL half_entry0 got=%h exp=%h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int t0, v0;
    build_expected(3, 1, 32'h40000, 32'h40000);
    t0 = taken_cnt; v0 = viol;
    bus.out_ready = 1'b0;
    accept_job(3, 1, 32'h40000, 32'h40000);
    repeat (19) step();
    total++; if (got_q.size() != 0 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_hold popped=%0d out_valid=%b exp 0/1", got_q.size(), bus.out_valid); end
    total++; if (taken_cnt - t0 != 2) begin bad++; $display("FAIL bp_taken20 got=%0d exp=2", taken_cnt - t0); end
    repeat (10) step();
    total++; if (taken_cnt - t0 != 2 || bus.sfg_done !== 1'b1 || bus.sfg_taken !== 1'b0) begin
      bad++; $display("FAIL bp_stall taken=%0d done=%b taken_now=%b exp 2/1/0", taken_cnt - t0, bus.sfg_done, bus.sfg_taken); end
`ifdef SF_SEQ_PERF_EN
    total++; if (bus.perf_stall == 0 || bus.perf_pixels !== 32'd2) begin
      bad++; $display("FAIL perf_mid stall=%0d pixels=%0d exp >0/2", bus.perf_stall, bus.perf_pixels); end
`endif
    bus.out_ready = 1'b1;
    wait_job_done(200, 1'b0, ok);
    step();
    total++; if (!ok || got_q.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (viol != v0) begin bad++; $display("FAIL bp_protocol violations=%0d exp=0", viol - v0); end
  endtask

  task automatic test_zero_size();
    int s0;
    s0 = start_cnt;
    got_q.delete();
    accept_job(0, 3, 32'h40000, 32'h40000);
    total++; if (bus.job_done !== 1'b1 || bus.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL zero_w_done got done=%b ready=%b exp 1/1", bus.job_done, bus.cfg_ready); end
    step();
    total++; if (bus.job_done !== 1'b0) begin bad++; $display("FAIL zero_w_pulse job_done=%b exp=0", bus.job_done); end
    accept_job(4, 0, 32'h40000, 32'h40000);
    total++; if (bus.job_done !== 1'b1) begin bad++; $display("FAIL zero_h_done job_done=%b exp=1", bus.job_done); end
    repeat (6) step();
    total++; if (start_cnt != s0 || got_q.size() != 0) begin
      bad++; $display("FAIL zero_no_start starts=%0d entries=%0d exp 0/0", start_cnt - s0, got_q.size()); end
  endtask

  task automatic test_reset_mid_job();
    bit ok, hit; int d0;
    bus.out_ready = 1'b0;
    accept_job(2, 2, 32'h40000, 32'h40000);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (g_busy && !g_done && bus.sfg_dx == 16'd1 && bus.sfg_dy == 16'd0) begin hit = 1'b1; break; end
    end
    total++; if (!hit || bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_reach hit=%0d out_valid=%b exp 1/1", hit, bus.out_valid); end
    d0 = done_cnt;
    resetn = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got valid=%b ready=%b exp 0/1", bus.out_valid, bus.cfg_ready); end
    total++; if (bus.sfg_start !== 1'b0 || bus.sfg_taken !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ctrl got start=%b taken=%b exp 0/0", bus.sfg_start, bus.sfg_taken); end
    repeat (2) step();
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    step();
    total++; if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt - d0); end
    build_expected(1, 1, 32'h30000, 32'h50000);
    accept_job(1, 1, 32'h30000, 32'h50000);
    wait_job_done(100, 1'b0, ok);
    step();
    total++; if (!ok || got_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0].last !== 1'b1) begin
      bad++; $display("FAIL mid_new_job ok=%0d n=%0d got=%h exp=%h", ok, got_q.size(), got_q.size() ? got_q[0] : '0, exp_q[0]); end
  endtask

  task automatic test_not_ready();
    bit ok; int s0;
    build_expected(2, 1, 32'h40000, 32'h28000);
    gen_block = 1'b1;
    s0 = start_cnt;
    accept_job(2, 1, 32'h40000, 32'h28000);
    for (int i = 0; i < 7; i++) begin
      total++; if (bus.sfg_start !== 1'b0) begin bad++; $display("FAIL nr_start_c%0d got=%b exp=0", i, bus.sfg_start); end
      step();
    end
    gen_block = 1'b0;
    #1;
    total++; if (bus.sfg_start !== 1'b1 || start_cnt != s0) begin
      bad++; $display("FAIL nr_release start=%b early_starts=%0d exp 1/0", bus.sfg_start, start_cnt - s0); end
    wait_job_done(200, 1'b0, ok);
    step();
    total++; if (!ok || got_q.size() != 2) begin bad++; $display("FAIL nr_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL nr_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok; int w, h, d0, v0; logic [31:0] fx, fy;
    for (int j = 0; j < 6; j++) begin
      w  = $urandom_range(1, 4);
      h  = $urandom_range(1, 3);
      fx = 32'($urandom_range(32'h10000, 32'h80000));
      fy = 32'($urandom_range(32'h10000, 32'h80000));
      build_expected(w, h, fx, fy);
      d0 = done_cnt; v0 = viol;
      accept_job(w, h, fx, fy);
      wait_job_done(600, 1'b1, ok);
      repeat (2) step();
      total++; if (!ok || got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d ok=%0d", j, got_q.size(), exp_q.size(), ok); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_entry%0d got=%h exp=%h", j, i, got_q[i], exp_q[i]); end
      end
      total++; if (done_cnt - d0 != 1 || viol != v0) begin
        bad++; $display("FAIL rnd%0d_protocol pulses=%0d violations=%0d exp 1/0", j, done_cnt - d0, viol - v0); end
`ifdef SF_SEQ_PERF_EN
      total++; if (bus.perf_pixels !== 32'(w * h)) begin
        bad++; $display("FAIL rnd%0d_perf_pixels got=%0d exp=%0d", j, bus.perf_pixels, w * h); end
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_half_scale();
    test_backpressure();
    test_zero_size();
    test_reset_mid_job();
    test_not_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
